ball_split_ctrl: RTL and testbench

Generates the child balls when a shot hits a bouncing ball. It is a parametrised successor to the fixed two-way speed split.
- On a hit pulse, latches the parent's speed and level.
- Emits NUM_CHILDREN spawn requests one at a time over a valid/ready handshake to the ball-slot allocator.
- A level-0 ball is popped with no children.
- Sits between the hit detector and the ball object pool in the game top.

---
 rtl/ball_split_ctrl_if.sv | 31 +++
 rtl/ball_split_ctrl.sv | 150 +++++++++++++++
 tb/tb_ball_split_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_split_ctrl_if.sv
// Spawn channel from the split controller to the ball-slot allocator.
// The controller holds a child descriptor valid until the allocator takes it.
interface ball_split_ctrl_if #(
    parameter int SPEED_W = 16,
    parameter int LEVEL_W = 3
);
    logic                      spawn_valid;
    logic                      spawn_ready;
    logic signed [SPEED_W-1:0] child_xspeed;
    logic signed [SPEED_W-1:0] child_yspeed;
    logic        [LEVEL_W-1:0] child_level;
    logic        [2:0]         child_idx;

    modport master (
        output spawn_valid,
        output child_xspeed,
        output child_yspeed,
        output child_level,
        output child_idx,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  child_xspeed,
        input  child_yspeed,
        input  child_level,
        input  child_idx,
        output spawn_ready
    );
endinterface

// File: rtl/ball_split_ctrl.sv
// Splits a hit ball into NUM_CHILDREN children offered one by one to the slot allocator.
// Optional macro SPLIT_DROP_CNT_EN adds drop_cnt, a saturating count of hits ignored while busy.
module ball_split_ctrl #(
    parameter int NUM_CHILDREN = 2,
    parameter int SPEED_W      = 16,
    parameter int LEVEL_W      = 3,
    parameter int X_STEP       = 16,
    parameter int MIN_YSPEED   = 64,
    parameter int MAX_XSPEED   = 512
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      hit,
    input  logic signed [SPEED_W-1:0] parent_xspeed,
    input  logic signed [SPEED_W-1:0] parent_yspeed,
    input  logic        [LEVEL_W-1:0] parent_level,
    ball_split_ctrl_if.master         spawn,
    output logic                      busy,
    output logic                      pop,
    output logic                      done
`ifdef SPLIT_DROP_CNT_EN
    ,
    output logic [7:0]                drop_cnt
`endif
);

    localparam int                  MAG_W    = SPEED_W + 8;
    localparam logic [2:0]          LAST_IDX = 3'(NUM_CHILDREN - 1);
    localparam logic [SPEED_W:0]    ONE_X    = (SPEED_W + 1)'(1);
    localparam logic [MAG_W-1:0]    MAX_MAG  = MAG_W'(MAX_XSPEED);
    localparam logic [MAG_W-1:0]    STEP_MAG = MAG_W'(X_STEP);
    localparam logic signed [SPEED_W-1:0] MIN_Y   = SPEED_W'(MIN_YSPEED);
    localparam logic signed [SPEED_W-1:0] S_MOST_NEG = {1'b1, {(SPEED_W - 1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] S_MOST_POS = {1'b0, {(SPEED_W - 1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT,
        DONE
    } state_t;

    state_t                    state;
    logic signed [SPEED_W-1:0] lat_x;
    logic signed [SPEED_W-1:0] lat_y;
    logic        [LEVEL_W-1:0] lat_level;
    logic        [2:0]         idx;

    logic        [2:0]         next_idx;
    logic        [SPEED_W:0]   abs_x;
    logic        [MAG_W-1:0]   mag_raw;
    logic        [MAG_W-1:0]   mag;
    logic signed [SPEED_W-1:0] mag_s;
    logic signed [SPEED_W-1:0] x_next;
    logic signed [SPEED_W-1:0] abs_y;
    logic signed [SPEED_W-1:0] up_y;
    logic signed [SPEED_W-1:0] y_next;

    // Descriptor of the child about to be presented: idx 0 from LOAD, idx+1 after an accept.
    always_comb begin
        next_idx = (state == EMIT) ? (idx + 3'd1) : 3'd0;
        abs_x    = lat_x[SPEED_W-1] ? ({1'b0, ~lat_x} + ONE_X) : {1'b0, lat_x};
        mag_raw  = MAG_W'(abs_x) + MAG_W'(next_idx >> 1) * STEP_MAG;
        mag      = (mag_raw > MAX_MAG) ? MAX_MAG : mag_raw;
        mag_s    = $signed(SPEED_W'(mag));
        x_next   = (lat_x[SPEED_W-1] ^ next_idx[0]) ? -mag_s : mag_s;
        abs_y    = (lat_y == S_MOST_NEG) ? S_MOST_POS
                 : (lat_y[SPEED_W-1] ? -lat_y : lat_y);
        up_y     = (abs_y < MIN_Y) ? MIN_Y : abs_y;
        y_next   = -up_y;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state              <= IDLE;
            lat_x              <= '0;
            lat_y              <= '0;
            lat_level          <= '0;
            idx                <= '0;
            busy               <= 1'b0;
            pop                <= 1'b0;
            done               <= 1'b0;
            spawn.spawn_valid  <= 1'b0;
            spawn.child_xspeed <= '0;
            spawn.child_yspeed <= '0;
            spawn.child_level  <= '0;
            spawn.child_idx    <= '0;
        end else begin
            pop  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (parent_level == '0) begin
                            pop <= 1'b1;
                        end else begin
                            lat_x     <= parent_xspeed;
                            lat_y     <= parent_yspeed;
                            lat_level <= parent_level;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    idx                <= next_idx;
                    spawn.spawn_valid  <= 1'b1;
                    spawn.child_xspeed <= x_next;
                    spawn.child_yspeed <= y_next;
                    spawn.child_level  <= lat_level - LEVEL_W'(1);
                    spawn.child_idx    <= next_idx;
                    state              <= EMIT;
                end
                EMIT: begin
                    // Fields only move on an accept, so the allocator sees a stable offer.
                    if (spawn.spawn_valid && spawn.spawn_ready) begin
                        if (idx == LAST_IDX) begin
                            spawn.spawn_valid <= 1'b0;
                            busy              <= 1'b0;
                            done              <= 1'b1;
                            state             <= DONE;
                        end else begin
                            idx                <= next_idx;
                            spawn.child_xspeed <= x_next;
                            spawn.child_yspeed <= y_next;
                            spawn.child_idx    <= next_idx;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPLIT_DROP_CNT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drop_cnt <= 8'd0;
        end else if (hit && (state == LOAD || state == EMIT) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ball_split_ctrl.sv
// Bench for ball_split_ctrl: two instances (2 and 4 children) share stimulus and are checked
// every cycle against a transaction-level model, plus hand-computed spot values.
module tb_ball_split_ctrl;

    localparam int SW   = 16;
    localparam int LW   = 3;
    localparam int XS   = 16;
    localparam int MINY = 64;
    localparam int MAXX = 512;

    logic                 clk = 1'b0;
    logic                 resetN;
    logic                 hit;
    logic signed [SW-1:0] px;
    logic signed [SW-1:0] py;
    logic        [LW-1:0] plvl;
    logic                 ready;
    logic                 busy2, pop2, done2;
    logic                 busy4, pop4, done4;
`ifdef SPLIT_DROP_CNT_EN
    logic [7:0]           drop2, drop4;
`endif

    ball_split_ctrl_if #(.SPEED_W(SW), .LEVEL_W(LW)) if2 ();
    ball_split_ctrl_if #(.SPEED_W(SW), .LEVEL_W(LW)) if4 ();

    assign if2.spawn_ready = ready;
    assign if4.spawn_ready = ready;

    ball_split_ctrl #(.NUM_CHILDREN(2), .SPEED_W(SW), .LEVEL_W(LW), .X_STEP(XS),
                      .MIN_YSPEED(MINY), .MAX_XSPEED(MAXX)) u_dut2 (
        .clk(clk), .resetN(resetN), .hit(hit),
        .parent_xspeed(px), .parent_yspeed(py), .parent_level(plvl),
        .spawn(if2), .busy(busy2), .pop(pop2), .done(done2)
`ifdef SPLIT_DROP_CNT_EN
        , .drop_cnt(drop2)
`endif
    );

    ball_split_ctrl #(.NUM_CHILDREN(4), .SPEED_W(SW), .LEVEL_W(LW), .X_STEP(XS),
                      .MIN_YSPEED(MINY), .MAX_XSPEED(MAXX)) u_dut4 (
        .clk(clk), .resetN(resetN), .hit(hit),
        .parent_xspeed(px), .parent_yspeed(py), .parent_level(plvl),
        .spawn(if4), .busy(busy4), .pop(pop4), .done(done4)
`ifdef SPLIT_DROP_CNT_EN
        , .drop_cnt(drop4)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: per instance, the list of children a split must produce and where we are in it.
    int m_phase [2];
    int m_k     [2];
    int m_cx    [2][8];
    int m_cy    [2];
    int m_lvl   [2];
    bit m_valid [2];
    bit m_busy  [2];
    bit m_pop   [2];
    bit m_done  [2];
    int m_drop  [2];

    function automatic int mag_abs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step(input int d);
        int n;
        int ax;
        int ay;
        int mg;
        n         = (d == 0) ? 2 : 4;
        m_pop[d]  = 1'b0;
        m_done[d] = 1'b0;
        if (hit && (m_phase[d] == 1 || m_phase[d] == 2) && m_drop[d] < 255)
            m_drop[d]++;
        case (m_phase[d])
            0: if (hit) begin
                if (int'(plvl) == 0) begin
                    m_pop[d] = 1'b1;
                end else begin
                    ax = mag_abs(int'(px));
                    ay = (int'(py) == -32768) ? 32767 : mag_abs(int'(py));
                    for (int k = 0; k < n; k++) begin
                        mg = ax + (k / 2) * XS;
                        if (mg > MAXX) mg = MAXX;
                        m_cx[d][k] = ((int'(px) >= 0) == (k % 2 == 0)) ? mg : -mg;
                    end
                    m_cy[d]    = (ay > MINY) ? -ay : -MINY;
                    m_lvl[d]   = int'(plvl) - 1;
                    m_busy[d]  = 1'b1;
                    m_phase[d] = 1;
                end
            end
            1: begin
                m_k[d]     = 0;
                m_valid[d] = 1'b1;
                m_phase[d] = 2;
            end
            2: if (ready) begin
                if (m_k[d] == n - 1) begin
                    m_valid[d] = 1'b0;
                    m_busy[d]  = 1'b0;
                    m_done[d]  = 1'b1;
                    m_phase[d] = 3;
                end else begin
                    m_k[d]++;
                end
            end
            default: m_phase[d] = 0;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetN);
            for (int d = 0; d < 2; d++) begin
                if (!resetN) begin
                    m_phase[d] = 0; m_k[d] = 0; m_valid[d] = 1'b0; m_busy[d] = 1'b0;
                    m_pop[d] = 1'b0; m_done[d] = 1'b0; m_drop[d] = 0;
                end else begin
                    model_step(d);
                end
            end
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_one(input int d, input logic v, input logic b, input logic p,
                               input logic dn, input int x, input int y, input int l,
                               input int i, input int dr);
        string tag;
        tag = (d == 0) ? "n2" : "n4";
        check_output({tag, ".spawn_valid"}, int'(v), int'(m_valid[d]));
        check_output({tag, ".busy"}, int'(b), int'(m_busy[d]));
        check_output({tag, ".pop"}, int'(p), int'(m_pop[d]));
        check_output({tag, ".done"}, int'(dn), int'(m_done[d]));
        if (m_valid[d]) begin
            check_output({tag, ".child_xspeed"}, x, m_cx[d][m_k[d]]);
            check_output({tag, ".child_yspeed"}, y, m_cy[d]);
            check_output({tag, ".child_level"}, l, m_lvl[d]);
            check_output({tag, ".child_idx"}, i, m_k[d]);
        end
`ifdef SPLIT_DROP_CNT_EN
        check_output({tag, ".drop_cnt"}, dr, m_drop[d]);
`else
        if (dr != 0) check_output({tag, ".drop_unused"}, dr, 0);
`endif
    endtask

    always @(negedge clk) begin
        compare_one(0, if2.spawn_valid, busy2, pop2, done2, int'(if2.child_xspeed),
                    int'(if2.child_yspeed), int'(if2.child_level), int'(if2.child_idx),
`ifdef SPLIT_DROP_CNT_EN
                    int'(drop2));
`else
                    0);
`endif
        compare_one(1, if4.spawn_valid, busy4, pop4, done4, int'(if4.child_xspeed),
                    int'(if4.child_yspeed), int'(if4.child_level), int'(if4.child_idx),
`ifdef SPLIT_DROP_CNT_EN
                    int'(drop4));
`else
                    0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One-cycle hit with the given parent; returns just after the edge that samples it.
    task automatic apply_stimulus(input int x, input int y, input int lvl);
        px   = SW'(x);
        py   = SW'(y);
        plvl = LW'(lvl);
        hit  = 1'b1;
        step();
        hit  = 1'b0;
    endtask

    int exp4 [4] = '{-500, 500, -512, 512};

    initial begin
        resetN = 1'b0;
        hit    = 1'b0;
        px     = '0;
        py     = '0;
        plvl   = '0;
        ready  = 1'b0;
        idle(3);
        check_output("rst.valid", int'(if2.spawn_valid), 0);
        check_output("rst.busy", int'(busy2), 0);
        check_output("rst.xspeed", int'(if4.child_xspeed), 0);
        check_output("rst.idx", int'(if4.child_idx), 0);
        resetN = 1'b1;
        idle(2);

        // Two-way split of a rightward, falling ball
        ready = 1'b1;
        apply_stimulus(100, 200, 2);
        check_output("t1.load_busy", int'(busy2), 1);
        step();
        check_output("t1.c0.x", int'(if2.child_xspeed), 100);
        check_output("t1.c0.y", int'(if2.child_yspeed), -200);
        check_output("t1.c0.lvl", int'(if2.child_level), 1);
        step();
        check_output("t1.c1.x", int'(if2.child_xspeed), -100);
        check_output("t1.c1.idx", int'(if2.child_idx), 1);
        step();
        check_output("t1.done", int'(done2), 1);
        idle(6);

        // Four-way split with X saturation and Y floor
        apply_stimulus(-500, -10, 3);
        step();
        for (int i = 0; i < 4; i++) begin
            check_output("t2.x", int'(if4.child_xspeed), exp4[i]);
            check_output("t2.y", int'(if4.child_yspeed), -64);
            check_output("t2.lvl", int'(if4.child_level), 2);
            step();
        end
        check_output("t2.done", int'(done4), 1);
        idle(4);

        // Level-0 ball pops
        apply_stimulus(123, 45, 0);
        check_output("t3.pop", int'(pop2), 1);
        check_output("t3.busy", int'(busy2), 0);
        step();
        check_output("t3.pop_end", int'(pop2), 0);
        idle(2);

        // Stall with an ignored hit, then a hit coinciding with the final accept
        ready = 1'b0;
        apply_stimulus(300, 100, 1);
        step();
        for (int s = 0; s < 5; s++) begin
            check_output("t4.stall_valid", int'(if2.spawn_valid), 1);
            check_output("t4.stall_idx", int'(if2.child_idx), 0);
            check_output("t4.stall_x", int'(if2.child_xspeed), 300);
            if (s == 2) apply_stimulus(-7, 9, 3);
            else step();
        end
`ifdef SPLIT_DROP_CNT_EN
        check_output("t4.drop1", int'(drop2), 1);
`endif
        ready = 1'b1;
        step();
        check_output("t4.c1.x", int'(if2.child_xspeed), -300);
        apply_stimulus(11, 22, 2);
        check_output("t4.done", int'(done2), 1);
        step();
        check_output("t4.no_restart", int'(busy2), 0);
`ifdef SPLIT_DROP_CNT_EN
        check_output("t4.drop2", int'(drop2), 2);
`endif
        idle(6);

        // Most-negative Y and zero X
        apply_stimulus(0, -32768, 1);
        step();
        check_output("t5.c0.y", int'(if2.child_yspeed), -32767);
        check_output("t5.c0.x", int'(if2.child_xspeed), 0);
        step();
        check_output("t5.c1.x", int'(if2.child_xspeed), 0);
        idle(6);

        // Asynchronous reset in the middle of emission
        apply_stimulus(50, 80, 2);
        step();
        step();
        check_output("t6.pre_idx", int'(if2.child_idx), 1);
        #2 resetN = 1'b0;
        #1;
        check_output("t6.rst_valid", int'(if2.spawn_valid), 0);
        check_output("t6.rst_busy", int'(busy2), 0);
        check_output("t6.rst_idx", int'(if2.child_idx), 0);
        check_output("t6.rst_valid4", int'(if4.spawn_valid), 0);
        resetN = 1'b1;
        step();
        apply_stimulus(60, 70, 2);
        step();
        check_output("t6.c0.idx", int'(if2.child_idx), 0);
        check_output("t6.c0.x", int'(if2.child_xspeed), 60);
        check_output("t6.c0.y", int'(if2.child_yspeed), -70);
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
